// File: rtl/gpio_bank_pkg.sv
// Shared constants for the Wishbone GPIO bank:
// register offsets, CFG field layout and reset default.
package gpio_bank_pkg;

    localparam int          CFG_W     = 12;
    localparam logic [11:0] CFG_RESET = 12'h001;

    localparam logic [7:0] OFF_DATA_IN  = 8'h80;
    localparam logic [7:0] OFF_DATA_OUT = 8'h84;
    localparam logic [7:0] OFF_RISE_EN  = 8'h88;
    localparam logic [7:0] OFF_FALL_EN  = 8'h8C;
    localparam logic [7:0] OFF_IRQ_STAT = 8'h90;

    localparam int CFG_OUT_VAL = 11;
    localparam int CFG_OEB_VAL = 10;
    localparam int CFG_IEB_VAL = 9;
    localparam int CFG_OUT_OVR = 8;
    localparam int CFG_OEB_OVR = 7;
    localparam int CFG_IEB_OVR = 6;
    localparam int CFG_SLOW    = 5;
    localparam int CFG_VTRIP   = 4;
    localparam int CFG_IBMODE  = 3;
    localparam int CFG_DM_LSB  = 0;

    typedef struct packed {
        logic       out_val;
        logic       oeb_val;
        logic       ieb_val;
        logic       out_ovr;
        logic       oeb_ovr;
        logic       ieb_ovr;
        logic       slow_sel;
        logic       vtrip_sel;
        logic       ib_mode_sel;
        logic [2:0] dm;
    } gpio_cfg_t;

    function automatic logic [5:0] word_idx(input logic [7:0] off);
        return off[7:2];
    endfunction

endpackage

// File: rtl/gpio_bank_chan.sv
// One GPIO channel: config register, input synchronizer,
// edge detector and pad override muxes.
module gpio_bank_chan
    import gpio_bank_pkg::*;
#(
    parameter logic [11:0] DEFAULTS    = CFG_RESET,
    parameter int          SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cfg_we,
    input  logic [11:0] cfg_wdata,
    input  logic        dout_we,
    input  logic        dout_val,
    input  logic        pad_in,
    input  logic        cpu_out,
    input  logic        cpu_oeb,
    input  logic        cpu_ieb,
    input  logic        rise_en,
    input  logic        fall_en,
    output logic [11:0] cfg,
    output logic        sync_in,
    output logic        edge_hit,
    output logic        pad_out,
    output logic        pad_oeb,
    output logic        pad_ieb,
    output logic        slow_sel,
    output logic        vtrip_sel,
    output logic        ib_mode_sel,
    output logic [2:0]  dm
);

    gpio_cfg_t              cfg_q, cfg_d;
    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   prev_q, prev_d;
    logic                   rise, fall;

    // Next state: CFG write, DATA_OUT alias, sync shift, edge history
    always_comb begin
        cfg_d = cfg_q;
        if (cfg_we) begin
            cfg_d = gpio_cfg_t'(cfg_wdata);
        end else if (dout_we) begin
            cfg_d.out_val = dout_val;
        end
        sync_d = {sync_q[SYNC_STAGES-2:0], pad_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    // Channel state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            cfg_q  <= gpio_cfg_t'(DEFAULTS);
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            cfg_q  <= cfg_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign sync_in  = sync_q[SYNC_STAGES-1];
    assign rise     = sync_in & ~prev_q;
    assign fall     = ~sync_in & prev_q;
    assign edge_hit = (rise & rise_en) | (fall & fall_en);

    assign cfg         = cfg_q;
    assign pad_out     = cfg_q.out_ovr ? cfg_q.out_val : cpu_out;
    assign pad_oeb     = cfg_q.oeb_ovr ? cfg_q.oeb_val : cpu_oeb;
    assign pad_ieb     = cfg_q.ieb_ovr ? cfg_q.ieb_val : cpu_ieb;
    assign slow_sel    = cfg_q.slow_sel;
    assign vtrip_sel   = cfg_q.vtrip_sel;
    assign ib_mode_sel = cfg_q.ib_mode_sel;
    assign dm          = cfg_q.dm;

endmodule

// File: rtl/gpio_bank_wb.sv
// Wishbone-mapped GPIO bank: register decode, edge interrupt
// status and NUM_GPIO channel instances.
module gpio_bank_wb
    import gpio_bank_pkg::*;
#(
    parameter int          NUM_GPIO      = 8,
    parameter logic [31:0] BASE_ADR      = 32'h2100_0000,
    parameter logic [11:0] GPIO_DEFAULTS = CFG_RESET,
    parameter int          SYNC_STAGES   = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic [31:0]           wb_adr_i,
    input  logic [31:0]           wb_dat_i,
    input  logic [3:0]            wb_sel_i,
    input  logic                  wb_we_i,
    input  logic                  wb_cyc_i,
    input  logic                  wb_stb_i,
    output logic                  wb_ack_o,
    output logic [31:0]           wb_dat_o,
    input  logic [NUM_GPIO-1:0]   pad_gpio_in,
    output logic [NUM_GPIO-1:0]   pad_gpio_out,
    output logic [NUM_GPIO-1:0]   pad_gpio_oeb,
    output logic [NUM_GPIO-1:0]   pad_gpio_ieb,
    output logic [NUM_GPIO-1:0]   pad_gpio_slow_sel,
    output logic [NUM_GPIO-1:0]   pad_gpio_vtrip_sel,
    output logic [NUM_GPIO-1:0]   pad_gpio_ib_mode_sel,
    output logic [3*NUM_GPIO-1:0] pad_gpio_dm,
    output logic [NUM_GPIO-1:0]   cpu_gpio_in,
    input  logic [NUM_GPIO-1:0]   cpu_gpio_out,
    input  logic [NUM_GPIO-1:0]   cpu_gpio_oeb,
    input  logic [NUM_GPIO-1:0]   cpu_gpio_ieb,
    output logic                  irq
);

    logic                ack_q, ack_d;
    logic [31:0]         dat_q, dat_d;
    logic [NUM_GPIO-1:0] rise_q, rise_d;
    logic [NUM_GPIO-1:0] fall_q, fall_d;
    logic [NUM_GPIO-1:0] stat_q, stat_d;

    logic                page_hit, req, wr_en, dout_we;
    logic [5:0]          wa;
    logic [31:0]         rdata;
    logic [NUM_GPIO-1:0] stat_clr;
    logic [NUM_GPIO-1:0] cfg_we;
    logic [NUM_GPIO-1:0] sync_in;
    logic [NUM_GPIO-1:0] edge_hit;
    logic [NUM_GPIO-1:0] out_val;
    logic [11:0]         cfg_rd [NUM_GPIO];

    // Decode: ack gates req so acks never land back to back
    assign page_hit = wb_adr_i[31:8] == BASE_ADR[31:8];
    assign req      = wb_cyc_i & wb_stb_i & page_hit & ~ack_q;
    assign wa       = word_idx(wb_adr_i[7:0]);
    assign wr_en    = req & wb_we_i & (wb_sel_i == 4'hF);
    assign dout_we  = wr_en & (wa == word_idx(OFF_DATA_OUT));

    genvar g;
    generate
        for (g = 0; g < NUM_GPIO; g++) begin : g_chan
            assign cfg_we[g]  = wr_en & (wa == 6'(g));
            assign out_val[g] = cfg_rd[g][CFG_OUT_VAL];

            gpio_bank_chan #(
                .DEFAULTS    (GPIO_DEFAULTS),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_chan (
                .clk         (clk),
                .resetn      (resetn),
                .cfg_we      (cfg_we[g]),
                .cfg_wdata   (wb_dat_i[11:0]),
                .dout_we     (dout_we),
                .dout_val    (wb_dat_i[g]),
                .pad_in      (pad_gpio_in[g]),
                .cpu_out     (cpu_gpio_out[g]),
                .cpu_oeb     (cpu_gpio_oeb[g]),
                .cpu_ieb     (cpu_gpio_ieb[g]),
                .rise_en     (rise_q[g]),
                .fall_en     (fall_q[g]),
                .cfg         (cfg_rd[g]),
                .sync_in     (sync_in[g]),
                .edge_hit    (edge_hit[g]),
                .pad_out     (pad_gpio_out[g]),
                .pad_oeb     (pad_gpio_oeb[g]),
                .pad_ieb     (pad_gpio_ieb[g]),
                .slow_sel    (pad_gpio_slow_sel[g]),
                .vtrip_sel   (pad_gpio_vtrip_sel[g]),
                .ib_mode_sel (pad_gpio_ib_mode_sel[g]),
                .dm          (pad_gpio_dm[3*g+2:3*g])
            );
        end
    endgenerate

    // Read mux: CFG window below 0x80, then the bank registers
    always_comb begin
        rdata = '0;
        for (int i = 0; i < NUM_GPIO; i++) begin
            if (wa == 6'(i)) begin
                rdata = {16'd0, sync_in[i], pad_gpio_out[i],
                         pad_gpio_oeb[i], pad_gpio_ieb[i], cfg_rd[i]};
            end
        end
        case (wa)
            word_idx(OFF_DATA_IN):  rdata = 32'(sync_in);
            word_idx(OFF_DATA_OUT): rdata = 32'(out_val);
            word_idx(OFF_RISE_EN):  rdata = 32'(rise_q);
            word_idx(OFF_FALL_EN):  rdata = 32'(fall_q);
            word_idx(OFF_IRQ_STAT): rdata = 32'(stat_q);
            default: ;
        endcase
    end

    // Next state for bus handshake, enables and W1C status (set wins)
    always_comb begin
        ack_d    = req;
        dat_d    = req ? rdata : 32'd0;
        rise_d   = rise_q;
        fall_d   = fall_q;
        stat_clr = '0;
        if (wr_en && wa == word_idx(OFF_RISE_EN)) begin
            rise_d = wb_dat_i[NUM_GPIO-1:0];
        end
        if (wr_en && wa == word_idx(OFF_FALL_EN)) begin
            fall_d = wb_dat_i[NUM_GPIO-1:0];
        end
        if (wr_en && wa == word_idx(OFF_IRQ_STAT)) begin
            stat_clr = wb_dat_i[NUM_GPIO-1:0];
        end
        stat_d = (stat_q & ~stat_clr) | edge_hit;
    end

    // Bank-level state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ack_q  <= 1'b0;
            dat_q  <= '0;
            rise_q <= '0;
            fall_q <= '0;
            stat_q <= '0;
        end else begin
            ack_q  <= ack_d;
            dat_q  <= dat_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            stat_q <= stat_d;
        end
    end

    assign wb_ack_o    = ack_q;
    assign wb_dat_o    = dat_q;
    assign cpu_gpio_in = sync_in;
    assign irq         = |stat_q;

endmodule

// File: tb/tb_gpio_bank_wb.sv
// Directed self-checking bench for gpio_bank_wb
// with hand-computed expected values.
module tb_gpio_bank_wb;

    localparam logic [31:0] BASE = 32'h2100_0000;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] wb_adr_i, wb_dat_i;
    logic [3:0]  wb_sel_i;
    logic        wb_we_i, wb_cyc_i, wb_stb_i;
    logic        wb_ack_o;
    logic [31:0] wb_dat_o;
    logic [7:0]  pad_gpio_in;
    logic [7:0]  pad_gpio_out, pad_gpio_oeb, pad_gpio_ieb;
    logic [7:0]  pad_gpio_slow_sel, pad_gpio_vtrip_sel;
    logic [7:0]  pad_gpio_ib_mode_sel;
    logic [23:0] pad_gpio_dm;
    logic [7:0]  cpu_gpio_in;
    logic [7:0]  cpu_gpio_out, cpu_gpio_oeb, cpu_gpio_ieb;
    logic        irq;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    gpio_bank_wb dut (
        .clk                  (clk),
        .resetn               (resetn),
        .wb_adr_i             (wb_adr_i),
        .wb_dat_i             (wb_dat_i),
        .wb_sel_i             (wb_sel_i),
        .wb_we_i              (wb_we_i),
        .wb_cyc_i             (wb_cyc_i),
        .wb_stb_i             (wb_stb_i),
        .wb_ack_o             (wb_ack_o),
        .wb_dat_o             (wb_dat_o),
        .pad_gpio_in          (pad_gpio_in),
        .pad_gpio_out         (pad_gpio_out),
        .pad_gpio_oeb         (pad_gpio_oeb),
        .pad_gpio_ieb         (pad_gpio_ieb),
        .pad_gpio_slow_sel    (pad_gpio_slow_sel),
        .pad_gpio_vtrip_sel   (pad_gpio_vtrip_sel),
        .pad_gpio_ib_mode_sel (pad_gpio_ib_mode_sel),
        .pad_gpio_dm          (pad_gpio_dm),
        .cpu_gpio_in          (cpu_gpio_in),
        .cpu_gpio_out         (cpu_gpio_out),
        .cpu_gpio_oeb         (cpu_gpio_oeb),
        .cpu_gpio_ieb         (cpu_gpio_ieb),
        .irq                  (irq)
    );

    // One bus transfer, bounded to 4 cycles waiting for ack
    task automatic wb_xfer(input logic [31:0] adr,
                           input logic [31:0] wdat,
                           input logic [3:0]  sel,
                           input logic        we,
                           output logic [31:0] rdat,
                           output logic        acked);
        wb_adr_i = adr;
        wb_dat_i = wdat;
        wb_sel_i = sel;
        wb_we_i  = we;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        acked    = 1'b0;
        rdat     = '0;
        for (int i = 0; i < 4 && !acked; i++) begin
            @(negedge clk);
            if (wb_ack_o) begin
                acked = 1'b1;
                rdat  = wb_dat_o;
            end
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] d);
        logic [31:0] r;
        logic        a;
        wb_xfer(BASE | 32'(off), d, 4'hF, 1'b1, r, a);
        n_cmp++;
        if (a !== 1'b1) begin
            n_bad++;
            $display("FAIL wr_ack off=%h got=%b want=1", off, a);
        end
    endtask

    task automatic rd(input logic [7:0] off, output logic [31:0] d);
        logic a;
        wb_xfer(BASE | 32'(off), 32'd0, 4'hF, 1'b0, d, a);
        n_cmp++;
        if (a !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_ack off=%h got=%b want=1", off, a);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        logic [31:0] d;
        resetn = 1'b0;
        cycles(3);
        resetn = 1'b1;
        cycles(2);
        rd(8'h00, d);
        n_cmp++;
        if (d !== 32'h0000_0001) begin
            n_bad++;
            $display("FAIL reset_cfg0 got=%h want=00000001", d);
        end
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_irq got=%b want=0", irq);
        end
        rd(8'h80, d);
        n_cmp++;
        if (d !== 32'd0) begin
            n_bad++;
            $display("FAIL reset_data_in got=%h want=0", d);
        end
        n_cmp++;
        if (pad_gpio_dm !== 24'h249249) begin
            n_bad++;
            $display("FAIL reset_dm got=%h want=249249", pad_gpio_dm);
        end
        cpu_gpio_oeb = 8'hF0;
        cpu_gpio_ieb = 8'h0F;
        cycles(1);
        n_cmp++;
        if ({pad_gpio_oeb, pad_gpio_ieb} !== 16'hF00F) begin
            n_bad++;
            $display("FAIL passthru got=%h want=f00f",
                     {pad_gpio_oeb, pad_gpio_ieb});
        end
        cpu_gpio_oeb = 8'h00;
        cpu_gpio_ieb = 8'h00;
    endtask

    task automatic test_override;
        logic [31:0] d;
        wr(8'h0C, 32'h0000_0980);
        n_cmp++;
        if (pad_gpio_out[3] !== 1'b1 || pad_gpio_oeb[3] !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_pad out=%b oeb=%b want out=1 oeb=0",
                     pad_gpio_out[3], pad_gpio_oeb[3]);
        end
        rd(8'h0C, d);
        n_cmp++;
        if (d !== 32'h0000_4980) begin
            n_bad++;
            $display("FAIL ovr_cfg3 got=%h want=00004980", d);
        end
        wr(8'h84, 32'd0);
        n_cmp++;
        if (pad_gpio_out[3] !== 1'b0) begin
            n_bad++;
            $display("FAIL ovr_dout0 got=%b want=0", pad_gpio_out[3]);
        end
        wr(8'h84, 32'h0000_00FF);
        n_cmp++;
        if (pad_gpio_out !== 8'h08) begin
            n_bad++;
            $display("FAIL ovr_dout_ff got=%h want=08", pad_gpio_out);
        end
        rd(8'h84, d);
        n_cmp++;
        if (d !== 32'h0000_00FF) begin
            n_bad++;
            $display("FAIL ovr_dout_rd got=%h want=000000ff", d);
        end
        wr(8'h0C, 32'h0000_0001);
        wr(8'h84, 32'd0);
    endtask

    task automatic test_rise;
        logic [31:0] d;
        wr(8'h88, 32'h0000_0001);
        @(posedge clk);
        #1 pad_gpio_in[0] = 1'b1;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b0 || cpu_gpio_in[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL rise_2clk irq=%b in=%b want irq=0 in=1",
                     irq, cpu_gpio_in[0]);
        end
        @(negedge clk);
        n_cmp++;
        if (irq !== 1'b1) begin
            n_bad++;
            $display("FAIL rise_3clk irq=%b want=1", irq);
        end
        rd(8'h90, d);
        n_cmp++;
        if (d !== 32'h0000_0001) begin
            n_bad++;
            $display("FAIL rise_stat got=%h want=00000001", d);
        end
        wr(8'h90, 32'h0000_0001);
        n_cmp++;
        if (irq !== 1'b0) begin
            n_bad++;
            $display("FAIL rise_w1c irq=%b want=0", irq);
        end
    endtask

    task automatic test_collision;
        logic [31:0] d;
        logic        a;
        wr(8'h8C, 32'h0000_0002);
        pad_gpio_in[1] = 1'b1;
        cycles(4);
        pad_gpio_in[1] = 1'b0;
        cycles(5);
        rd(8'h90, d);
        n_cmp++;
        if (d !== 32'h0000_0002) begin
            n_bad++;
            $display("FAIL fall_stat got=%h want=00000002", d);
        end
        pad_gpio_in[1] = 1'b1;
        cycles(5);
        @(posedge clk);
        #1 pad_gpio_in[1] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 wb_xfer(BASE | 32'h90, 32'h2, 4'hF, 1'b1, d, a);
        rd(8'h90, d);
        n_cmp++;
        if (d !== 32'h0000_0002 || irq !== 1'b1) begin
            n_bad++;
            $display("FAIL collide got=%h irq=%b want=00000002 irq=1",
                     d, irq);
        end
        wr(8'h90, 32'h0000_0002);
        rd(8'h90, d);
        n_cmp++;
        if (d !== 32'd0 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL clr_after got=%h irq=%b want=0 irq=0", d, irq);
        end
    endtask

    task automatic test_bus_edges;
        logic [31:0] d;
        logic        a;
        wb_xfer(BASE, 32'h0000_0FFF, 4'h1, 1'b1, d, a);
        n_cmp++;
        if (a !== 1'b1) begin
            n_bad++;
            $display("FAIL partial_ack got=%b want=1", a);
        end
        rd(8'h00, d);
        n_cmp++;
        if (d[11:0] !== 12'h001) begin
            n_bad++;
            $display("FAIL partial_nochg got=%h want=001", d[11:0]);
        end
        wr(8'h40, 32'hFFFF_FFFF);
        rd(8'h40, d);
        n_cmp++;
        if (d !== 32'd0) begin
            n_bad++;
            $display("FAIL hole_rd got=%h want=0", d);
        end
        wb_xfer(BASE + 32'h100, 32'h0000_0FFF, 4'hF, 1'b1, d, a);
        n_cmp++;
        if (a !== 1'b0) begin
            n_bad++;
            $display("FAIL oop_ack got=%b want=0", a);
        end
        rd(8'h00, d);
        n_cmp++;
        if (d[11:0] !== 12'h001) begin
            n_bad++;
            $display("FAIL oop_nochg got=%h want=001", d[11:0]);
        end
    endtask

    task automatic test_back_to_back;
        int  acks;
        int  dbl;
        logic last;
        acks = 0;
        dbl  = 0;
        last = 1'b0;
        @(posedge clk);
        #1;
        wb_adr_i = BASE | 32'h80;
        wb_we_i  = 1'b0;
        wb_sel_i = 4'hF;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (wb_ack_o === 1'b1) begin
                acks++;
                if (last) dbl++;
            end
            last = wb_ack_o;
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        cycles(2);
        n_cmp++;
        if (acks != 2 || dbl != 0) begin
            n_bad++;
            $display("FAIL b2b acks=%0d dbl=%0d want acks=2 dbl=0",
                     acks, dbl);
        end
    endtask

    task automatic test_reset_mid;
        logic [31:0] d;
        int          acks;
        pad_gpio_in = 8'h00;
        cycles(4);
        wr(8'h00, 32'h0000_00A5);
        rd(8'h00, d);
        n_cmp++;
        if (d !== 32'h0000_00A5 || pad_gpio_slow_sel[0] !== 1'b1) begin
            n_bad++;
            $display("FAIL mid_pre got=%h slow=%b want=000000a5 slow=1",
                     d, pad_gpio_slow_sel[0]);
        end
        acks = 0;
        @(posedge clk);
        #1;
        wb_adr_i = BASE;
        wb_dat_i = 32'h0000_0FFF;
        wb_sel_i = 4'hF;
        wb_we_i  = 1'b1;
        wb_cyc_i = 1'b1;
        wb_stb_i = 1'b1;
        @(negedge clk);
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (wb_ack_o !== 1'b0) acks++;
        end
        wb_cyc_i = 1'b0;
        wb_stb_i = 1'b0;
        wb_we_i  = 1'b0;
        resetn   = 1'b1;
        n_cmp++;
        if (acks != 0) begin
            n_bad++;
            $display("FAIL mid_ack acks=%0d want=0", acks);
        end
        cycles(1);
        rd(8'h00, d);
        n_cmp++;
        if (d !== 32'h0000_0001 || pad_gpio_slow_sel[0] !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_cfg got=%h slow=%b want=00000001 slow=0",
                     d, pad_gpio_slow_sel[0]);
        end
        rd(8'h88, d);
        n_cmp++;
        if (d !== 32'd0 || irq !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_en got=%h irq=%b want=0 irq=0", d, irq);
        end
    endtask

    initial begin
        resetn       = 1'b0;
        wb_adr_i     = '0;
        wb_dat_i     = '0;
        wb_sel_i     = '0;
        wb_we_i      = 1'b0;
        wb_cyc_i     = 1'b0;
        wb_stb_i     = 1'b0;
        pad_gpio_in  = '0;
        cpu_gpio_out = '0;
        cpu_gpio_oeb = '0;
        cpu_gpio_ieb = '0;
        test_reset();
        test_override();
        test_rise();
        test_collision();
        test_bus_edges();
        test_back_to_back();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
